uart_engine: RTL

UART_ENGINE -- requirements
Module: uart_engine

---
 rtl/uart_engine_if.sv | 21 ++
 rtl/uart_engine.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_engine_if.sv
// rtl/uart_engine_if.sv - TX write and RX read handshake bundle for uart_engine
interface uart_engine_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_perr;
    logic       rx_ferr;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid, rx_perr, rx_ferr
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid, rx_perr, rx_ferr
    );
endinterface

// File: rtl/uart_engine.sv
// rtl/uart_engine.sv - UART TX/RX engine with FIFOs; UART_ENGINE_LOOPBACK_EN adds a loopback port
module uart_engine #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
`ifdef UART_ENGINE_LOOPBACK_EN
    input  logic         loopback,
`endif
    input  logic [15:0]  baud_div,
    uart_engine_if.slave bus,
    output logic         tx_serial,
    input  logic         rx_serial,
    output logic         irq_tx_empty,
    output logic         irq_rx_full,
    output logic         rx_overrun
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int RX_W  = DATA_BITS + 2;
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;

    // TX FIFO
    logic [DATA_BITS-1:0] tx_mem_q [FIFO_DEPTH];
    logic [PTR_W:0]       tx_wr_q, tx_rd_q;
    logic                 tx_empty, tx_full, tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    assign tx_empty     = (tx_wr_q == tx_rd_q);
    assign tx_full      = (tx_wr_q[PTR_W] != tx_rd_q[PTR_W]) &&
                          (tx_wr_q[PTR_W-1:0] == tx_rd_q[PTR_W-1:0]);
    assign bus.tx_ready = !tx_full && !rst;
    assign tx_push      = bus.tx_valid && bus.tx_ready;
    assign tx_head      = tx_mem_q[tx_rd_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wr_q[PTR_W-1:0]] <= bus.tx_data[DATA_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_q <= '0;
            tx_rd_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + PTR_ONE;
            if (tx_pop)  tx_rd_q <= tx_rd_q + PTR_ONE;
        end
    end

    // TX FSM
    state_e               tx_state_q, tx_state_d;
    logic [15:0]          tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d, tx_serial_q, tx_serial_d;
    logic                 tx_bit_end, tx_load;

    assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= ST_IDLE;
            tx_cnt_q    <= '0;
            tx_div_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_par_q    <= 1'b0;
            tx_serial_q <= 1'b1;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_div_q    <= tx_div_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_par_q    <= tx_par_d;
            tx_serial_q <= tx_serial_d;
        end
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q + 16'd1;
        tx_div_d    = tx_div_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_par_d    = tx_par_q;
        tx_serial_d = tx_serial_q;
        tx_load     = 1'b0;
        tx_pop      = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d = '0;
                tx_load  = !tx_empty;
            end
            ST_START: if (tx_bit_end) begin
                tx_state_d  = ST_DATA;
                tx_cnt_d    = '0;
                tx_bit_d    = '0;
                tx_serial_d = tx_shift_q[0];
            end
            ST_DATA: if (tx_bit_end) begin
                tx_cnt_d = '0;
                if (tx_bit_q == LAST_DATA) begin
                    tx_bit_d = '0;
                    if (PARITY != 0) begin
                        tx_state_d  = ST_PARITY;
                        tx_serial_d = tx_par_q;
                    end else begin
                        tx_state_d  = ST_STOP;
                        tx_serial_d = 1'b1;
                    end
                end else begin
                    tx_bit_d    = tx_bit_q + 3'd1;
                    tx_shift_d  = tx_shift_q >> 1;
                    tx_serial_d = tx_shift_d[0];
                end
            end
            ST_PARITY: if (tx_bit_end) begin
                tx_state_d  = ST_STOP;
                tx_cnt_d    = '0;
                tx_serial_d = 1'b1;
            end
            ST_STOP: if (tx_bit_end) begin
                tx_cnt_d = '0;
                if (tx_bit_q == LAST_STOP) begin
                    tx_bit_d   = '0;
                    tx_state_d = ST_IDLE;
                    tx_load    = !tx_empty;
                end else begin
                    tx_bit_d = tx_bit_q + 3'd1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
        // Loading straight from the end of a stop bit keeps frames gap-free
        if (tx_load) begin
            tx_pop      = 1'b1;
            tx_state_d  = ST_START;
            tx_cnt_d    = '0;
            tx_div_d    = baud_div;
            tx_shift_d  = tx_head;
            tx_par_d    = (PARITY == 1) ? ~^tx_head : ^tx_head;
            tx_serial_d = 1'b0;
        end
    end

    // Serial line routing
    logic rx_line;
`ifdef UART_ENGINE_LOOPBACK_EN
    assign rx_line   = loopback ? tx_serial_q : rx_serial;
    assign tx_serial = loopback ? 1'b1 : tx_serial_q;
`else
    assign rx_line   = rx_serial;
    assign tx_serial = tx_serial_q;
`endif

    // RX FIFO
    logic [RX_W-1:0] rx_mem_q [FIFO_DEPTH];
    logic [PTR_W:0]  rx_wr_q, rx_rd_q;
    logic            rx_empty, rx_full, rx_push, rx_pop, rx_wr_en, rx_ovr_q;
    logic [RX_W-1:0] rx_head, rx_word;

    assign rx_empty     = (rx_wr_q == rx_rd_q);
    assign rx_full      = (rx_wr_q[PTR_W] != rx_rd_q[PTR_W]) &&
                          (rx_wr_q[PTR_W-1:0] == rx_rd_q[PTR_W-1:0]);
    assign bus.rx_valid = !rx_empty;
    assign rx_pop       = bus.rx_valid && bus.rx_ready;
    assign rx_wr_en     = rx_push && (!rx_full || rx_pop);
    assign rx_head      = rx_mem_q[rx_rd_q[PTR_W-1:0]];

    always_comb begin
        bus.rx_data = '0;
        bus.rx_perr = 1'b0;
        bus.rx_ferr = 1'b0;
        if (!rx_empty) begin
            bus.rx_data[DATA_BITS-1:0] = rx_head[DATA_BITS-1:0];
            bus.rx_ferr                = rx_head[DATA_BITS];
            bus.rx_perr                = rx_head[DATA_BITS+1];
        end
    end

    always_ff @(posedge clk) begin
        if (rx_wr_en) rx_mem_q[rx_wr_q[PTR_W-1:0]] <= rx_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_ovr_q <= 1'b0;
        end else begin
            if (rx_wr_en) rx_wr_q <= rx_wr_q + PTR_ONE;
            if (rx_pop)   rx_rd_q <= rx_rd_q + PTR_ONE;
            rx_ovr_q <= rx_push && !rx_wr_en;
        end
    end

    // RX synchroniser and FSM
    state_e               rx_state_q, rx_state_d;
    logic [15:0]          rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q, rx_in, rx_mid, rx_end;

    assign rx_in   = rx_s2_q;
    assign rx_mid  = (rx_cnt_q == (rx_div_q >> 1) - 16'd1);
    assign rx_end  = (rx_cnt_q == rx_div_q - 16'd1);
    assign rx_word = {rx_perr_q, ~rx_in, rx_shift_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_s1_q    <= rx_line;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_perr_d  = rx_perr_q;
        rx_push    = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_in) begin
                    rx_state_d = ST_START;
                    rx_div_d   = baud_div;
                    rx_perr_d  = 1'b0;
                end
            end
            // A start bit that is high again at mid-bit was a glitch
            ST_START: if (rx_mid) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_in ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (rx_end) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_in, rx_shift_q[DATA_BITS-1:1]};
                if (rx_bit_q == LAST_DATA) begin
                    rx_state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                end else begin
                    rx_bit_d = rx_bit_q + 3'd1;
                end
            end
            ST_PARITY: if (rx_end) begin
                rx_cnt_d   = '0;
                rx_perr_d  = (PARITY == 1) ? ~^{rx_shift_q, rx_in} : ^{rx_shift_q, rx_in};
                rx_state_d = ST_STOP;
            end
            ST_STOP: if (rx_end) begin
                rx_push    = 1'b1;
                rx_state_d = ST_IDLE;
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    assign irq_tx_empty = tx_empty && (tx_state_q == ST_IDLE);
    assign irq_rx_full  = rx_full;
    assign rx_overrun   = rx_ovr_q;
endmodule
